// File: rtl/cory_pkg.sv
// rtl/cory_pkg.sv - shared state encoding and mode constants for the cory stream blocks
package cory_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } cory_state_e;

  localparam int CORY_MUX_BEAT = 0;
  localparam int CORY_MUX_PKT  = 1;

endpackage

// File: rtl/cory_queue.sv
// rtl/cory_queue.sv - valid/ready FIFO of depth Q, straight wires when Q is 0
module cory_queue #(
  parameter int W = 9,
  parameter int Q = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_v,
  input  logic [W-1:0] i_d,
  output logic         o_r,
  output logic         o_v,
  output logic [W-1:0] o_d,
  input  logic         i_r
);

  if (Q == 0) begin : g_pass
    wire w_unused = clk ^ reset;
    assign o_v = i_v;
    assign o_d = i_d;
    assign o_r = i_r;
  end else begin : g_fifo
    localparam int PW = (Q > 1) ? $clog2(Q) : 1;
    localparam int CW = $clog2(Q + 1);

    logic [W-1:0]  r_mem [Q];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_last;
    logic          w_push;
    logic          w_pop;

    // Pointers wrap at Q, which need not be a power of two
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(Q - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_r    = (r_cnt < CW'(Q));
    assign o_v    = (r_cnt != '0);
    assign w_push = i_v && o_r;
    assign w_pop  = o_v && i_r;
    // When empty the output shows the last popped entry instead of a stale slot
    assign o_d    = o_v ? r_mem[r_rp] : r_last;

    // Storage write; contents need no reset since they are only read when counted
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_d;
    end

    // Pointer, occupancy and hold-register update
    always_ff @(posedge clk) begin
      if (reset) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        r_last <= '0;
      end else begin
        if (w_push) r_wp <= nxt(r_wp);
        if (w_pop) begin
          r_rp   <= nxt(r_rp);
          r_last <= r_mem[r_rp];
        end
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

// File: rtl/cory_muxn.sv
// rtl/cory_muxn.sv - C-way stream mux steered by a select stream, optional packet lock and output queue
module cory_muxn
  import cory_pkg::*;
#(
  parameter int  N = 8,
  parameter int  C = 4,
  parameter int  Q = 0,
  parameter int  M = 0,
  localparam int S = $clog2(C)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [C-1:0]   i_a_v,
  input  logic [C*N-1:0] i_a_d,
  input  logic [C-1:0]   i_a_l,
  output logic [C-1:0]   o_a_r,
  input  logic           i_s_v,
  input  logic [S-1:0]   i_s_d,
  output logic           o_s_r,
  output logic           o_z_v,
  output logic [N-1:0]   o_z_d,
  output logic           o_z_l,
  input  logic           i_z_r,
  output logic           o_err
);

  cory_state_e  r_state;
  logic [S-1:0] r_lock;

  logic         w_sel_ok;
  logic         w_pkt;
  logic [S-1:0] w_ch;
  logic         w_ch_ok;
  logic         w_qual;
  logic         w_av;
  logic [N-1:0] w_ad;
  logic         w_al;
  logic         w_int_v;
  logic         w_int_r;
  logic [N:0]   w_int_d;
  logic [N:0]   w_z;
  logic         w_xfer;

  // Select indices >= C only exist when C is not a power of two
  assign w_sel_ok = ({1'b0, i_s_d} < (S + 1)'(C));
  assign w_pkt    = (M == CORY_MUX_PKT) && (r_state == ST_PKT);
  assign w_ch     = w_pkt ? r_lock : i_s_d;
  assign w_ch_ok  = w_pkt || w_sel_ok;
  assign w_qual   = w_pkt || (i_s_v && w_sel_ok);

  // Pick the steered channel's valid/data/last, zero when the index is out of range
  always_comb begin
    w_av = 1'b0;
    w_ad = '0;
    w_al = 1'b0;
    if (w_ch_ok) begin
      w_av = i_a_v[w_ch];
      w_ad = i_a_d[w_ch*N +: N];
      w_al = i_a_l[w_ch];
    end
  end

  assign w_int_v = w_qual && w_av;
  assign w_int_d = {(M == CORY_MUX_BEAT) ? 1'b1 : w_al, w_ad};
  assign w_xfer  = w_int_v && w_int_r;
  assign o_err   = i_s_v && !w_sel_ok && !w_pkt;

  // At most one channel sees ready: the steered one, when a token or lock qualifies it
  always_comb begin
    o_a_r = '0;
    for (int k = 0; k < C; k++) begin
      o_a_r[k] = w_qual && (w_ch == S'(k)) && w_int_r;
    end
  end

  // Beat mode consumes a token with every beat; packet mode only on the first beat
  always_comb begin
    o_s_r = o_err;
    if (M == CORY_MUX_BEAT) begin
      if (w_sel_ok && w_int_r && w_av) o_s_r = 1'b1;
    end else begin
      if (!w_pkt && w_xfer) o_s_r = 1'b1;
    end
  end

  // Packet lock: hold the channel from a non-last first beat until its last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_lock  <= '0;
    end else if (M == CORY_MUX_PKT) begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && !w_al) begin
            r_state <= ST_PKT;
            r_lock  <= i_s_d;
          end
        end
        ST_PKT: begin
          if (w_xfer && w_al) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cory_queue #(
    .W(N + 1),
    .Q(Q)
  ) u_queue (
    .clk  (clk),
    .reset(reset),
    .i_v  (w_int_v),
    .i_d  (w_int_d),
    .o_r  (w_int_r),
    .o_v  (o_z_v),
    .o_d  (w_z),
    .i_r  (i_z_r)
  );

  assign o_z_l = w_z[N];
  assign o_z_d = w_z[N-1:0];

endmodule

// File: tb/tb_cory_muxn.sv
// tb/tb_cory_muxn.sv - directed and randomised-backpressure checks of cory_muxn in four configurations
module tb_cory_muxn;

  logic clk;
  logic reset;

  // u0: C=4 M=0 Q=0
  logic [3:0]  u0_a_v, u0_a_l, u0_a_r;
  logic [31:0] u0_a_d;
  logic        u0_s_v, u0_s_r, u0_z_v, u0_z_l, u0_z_r, u0_err;
  logic [1:0]  u0_s_d;
  logic [7:0]  u0_z_d;
  // u1: C=3 M=0 Q=2
  logic [2:0]  u1_a_v, u1_a_l, u1_a_r;
  logic [23:0] u1_a_d;
  logic        u1_s_v, u1_s_r, u1_z_v, u1_z_l, u1_z_r, u1_err;
  logic [1:0]  u1_s_d;
  logic [7:0]  u1_z_d;
  // u2: C=4 M=1 Q=2
  logic [3:0]  u2_a_v, u2_a_l, u2_a_r;
  logic [31:0] u2_a_d;
  logic        u2_s_v, u2_s_r, u2_z_v, u2_z_l, u2_z_r, u2_err;
  logic [1:0]  u2_s_d;
  logic [7:0]  u2_z_d;
  // u3: C=4 M=0 Q=3
  logic [3:0]  u3_a_v, u3_a_l, u3_a_r;
  logic [31:0] u3_a_d;
  logic        u3_s_v, u3_s_r, u3_z_v, u3_z_l, u3_z_r, u3_err;
  logic [1:0]  u3_s_d;
  logic [7:0]  u3_z_d;

  int n_vec = 0;
  int n_bad = 0;

  cory_muxn #(.N(8), .C(4), .Q(0), .M(0)) u0 (
    .clk(clk), .reset(reset), .i_a_v(u0_a_v), .i_a_d(u0_a_d), .i_a_l(u0_a_l), .o_a_r(u0_a_r),
    .i_s_v(u0_s_v), .i_s_d(u0_s_d), .o_s_r(u0_s_r), .o_z_v(u0_z_v), .o_z_d(u0_z_d),
    .o_z_l(u0_z_l), .i_z_r(u0_z_r), .o_err(u0_err));

  cory_muxn #(.N(8), .C(3), .Q(2), .M(0)) u1 (
    .clk(clk), .reset(reset), .i_a_v(u1_a_v), .i_a_d(u1_a_d), .i_a_l(u1_a_l), .o_a_r(u1_a_r),
    .i_s_v(u1_s_v), .i_s_d(u1_s_d), .o_s_r(u1_s_r), .o_z_v(u1_z_v), .o_z_d(u1_z_d),
    .o_z_l(u1_z_l), .i_z_r(u1_z_r), .o_err(u1_err));

  cory_muxn #(.N(8), .C(4), .Q(2), .M(1)) u2 (
    .clk(clk), .reset(reset), .i_a_v(u2_a_v), .i_a_d(u2_a_d), .i_a_l(u2_a_l), .o_a_r(u2_a_r),
    .i_s_v(u2_s_v), .i_s_d(u2_s_d), .o_s_r(u2_s_r), .o_z_v(u2_z_v), .o_z_d(u2_z_d),
    .o_z_l(u2_z_l), .i_z_r(u2_z_r), .o_err(u2_err));

  cory_muxn #(.N(8), .C(4), .Q(3), .M(0)) u3 (
    .clk(clk), .reset(reset), .i_a_v(u3_a_v), .i_a_d(u3_a_d), .i_a_l(u3_a_l), .o_a_r(u3_a_r),
    .i_s_v(u3_s_v), .i_s_d(u3_s_d), .o_s_r(u3_s_r), .o_z_v(u3_z_v), .o_z_d(u3_z_d),
    .o_z_l(u3_z_l), .i_z_r(u3_z_r), .o_err(u3_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0] t1_tok [3] = '{2'd2, 2'd0, 2'd3};
  logic [7:0] t1_dat [3] = '{8'hC2, 8'hA0, 8'hD3};
  logic [3:0] t1_rdy [3] = '{4'b0100, 4'b0001, 4'b1000};

  initial begin
    int acc;
    int sb;
    int rb;
    int occ_max;
    int k;
    logic pop;
    logic take;

    reset = 1'b1;
    u0_a_v = '0; u0_a_l = '0; u0_a_d = '0; u0_s_v = 0; u0_s_d = '0; u0_z_r = 1;
    u1_a_v = '0; u1_a_l = '0; u1_a_d = '0; u1_s_v = 0; u1_s_d = '0; u1_z_r = 1;
    u2_a_v = '0; u2_a_l = '0; u2_a_d = '0; u2_s_v = 0; u2_s_d = '0; u2_z_r = 1;
    u3_a_v = '0; u3_a_l = '0; u3_a_d = '0; u3_s_v = 0; u3_s_d = '0; u3_z_r = 1;

    // reset state
    @(negedge clk);
    chk("rst_u2_z_v", u2_z_v, 0);
    chk("rst_u2_z_d", u2_z_d, 8'h00);
    chk("rst_u2_z_l", u2_z_l, 0);
    chk("rst_u2_s_r", u2_s_r, 0);
    chk("rst_u2_a_r", u2_a_r, 4'b0000);
    chk("rst_u0_err", u0_err, 0);
    @(negedge clk);
    reset = 1'b0;

    // beat mode, pass-through: tokens 2,0,3 with all channels valid
    u0_a_v = 4'hF;
    u0_a_d = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    u0_s_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      u0_s_d = t1_tok[i];
      #1;
      chk("t1_z_v", u0_z_v, 1);
      chk("t1_z_d", u0_z_d, t1_dat[i]);
      chk("t1_z_l", u0_z_l, 1);
      chk("t1_a_r", u0_a_r, t1_rdy[i]);
      chk("t1_s_r", u0_s_r, 1);
    end
    @(negedge clk);
    u0_s_v = 1'b0;
    #1;
    chk("t1_idle_a_r", u0_a_r, 4'b0000);
    chk("t1_idle_s_r", u0_s_r, 1);

    // out-of-range token 3 with C=3, then token 1
    @(negedge clk);
    u1_a_v = 3'b111;
    u1_a_d = {8'h62, 8'h61, 8'h60};
    u1_s_v = 1'b1;
    u1_s_d = 2'd3;
    #1;
    chk("t2_err", u1_err, 1);
    chk("t2_err_s_r", u1_s_r, 1);
    chk("t2_err_a_r", u1_a_r, 3'b000);
    @(negedge clk);
    chk("t2_err_z_v", u1_z_v, 0);
    u1_s_d = 2'd1;
    #1;
    chk("t2_ok_err", u1_err, 0);
    chk("t2_ok_a_r", u1_a_r, 3'b010);
    chk("t2_ok_s_r", u1_s_r, 1);
    @(negedge clk);
    chk("t2_ok_z_v", u1_z_v, 1);
    chk("t2_ok_z_d", u1_z_d, 8'h61);
    u1_s_v = 1'b0;
    u1_a_v = 3'b000;
    #1;
    chk("t2_nosel_a_r", u1_a_r, 3'b000);
    @(negedge clk);
    chk("t2_empty_z_v", u1_z_v, 0);
    chk("t2_hold_z_d", u1_z_d, 8'h61);

    // backpressure: Q=2 with sink stalled for 5 cycles, ch0 streaming
    u1_z_r = 1'b0;
    u1_s_v = 1'b1;
    u1_s_d = 2'd0;
    u1_a_v = 3'b001;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      u1_a_d[7:0] = 8'h70 + 8'(acc);
      #1;
      if (u1_a_r[0]) acc++;
      @(negedge clk);
    end
    chk("t4_accepted", acc, 2);
    chk("t4_full_a_r", u1_a_r, 3'b000);
    chk("t4_full_s_r", u1_s_r, 0);
    u1_z_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u1_a_d[7:0] = 8'h70 + 8'(acc);
      #1;
      chk("t4_drain_z_v", u1_z_v, 1);
      chk("t4_drain_z_d", u1_z_d, 8'h70 + 8'(i));
      if (u1_a_r[0]) acc++;
      @(negedge clk);
    end
    u1_a_v = 3'b000;
    u1_s_v = 1'b0;

    // packet mode: 3-beat packet on ch1, token switched to 2 after beat 1
    u2_a_v = 4'hF;
    u2_a_l = 4'b1100;
    u2_a_d = {8'hD3, 8'h90, 8'h81, 8'hA0};
    u2_s_v = 1'b1;
    u2_s_d = 2'd1;
    #1;
    chk("t3_b1_s_r", u2_s_r, 1);
    chk("t3_b1_a_r", u2_a_r, 4'b0010);
    @(negedge clk);
    chk("t3_b1_z_d", u2_z_d, 8'h81);
    u2_s_d = 2'd2;
    u2_a_d[15:8] = 8'h82;
    #1;
    chk("t3_b2_s_r", u2_s_r, 0);
    chk("t3_b2_a_r", u2_a_r, 4'b0010);
    @(negedge clk);
    chk("t3_b2_z_d", u2_z_d, 8'h82);
    chk("t3_b2_z_l", u2_z_l, 0);
    u2_a_d[15:8] = 8'h83;
    u2_a_l[1] = 1'b1;
    #1;
    chk("t3_b3_s_r", u2_s_r, 0);
    chk("t3_b3_a_r", u2_a_r, 4'b0010);
    @(negedge clk);
    chk("t3_b3_z_d", u2_z_d, 8'h83);
    chk("t3_b3_z_l", u2_z_l, 1);
    #1;
    chk("t3_next_a_r", u2_a_r, 4'b0100);
    chk("t3_next_s_r", u2_s_r, 1);
    @(negedge clk);
    chk("t3_next_z_d", u2_z_d, 8'h90);
    chk("t3_next_z_l", u2_z_l, 1);
    u2_s_v = 1'b0;

    // packet mode: reset after beat 2 of a 4-beat packet on ch0
    @(negedge clk);
    u2_a_l = 4'b1000;
    u2_a_d[7:0] = 8'hA0;
    u2_s_v = 1'b1;
    u2_s_d = 2'd0;
    #1;
    chk("t5_b1_a_r", u2_a_r, 4'b0001);
    @(negedge clk);
    u2_s_d = 2'd3;
    u2_a_d[7:0] = 8'hA1;
    #1;
    chk("t5_b2_a_r", u2_a_r, 4'b0001);
    chk("t5_b2_s_r", u2_s_r, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_post_z_v", u2_z_v, 0);
    chk("t5_post_a_r", u2_a_r, 4'b1000);
    chk("t5_post_s_r", u2_s_r, 1);
    @(negedge clk);
    chk("t5_new_z_v", u2_z_v, 1);
    chk("t5_new_z_d", u2_z_d, 8'hD3);
    u2_s_v = 1'b0;
    u2_a_v = 4'h0;

    // Q=3 with random sink ready over 50 beats, token rotates through channels
    sb = 0;
    rb = 0;
    occ_max = 0;
    for (int cyc = 0; cyc < 2000 && rb < 50; cyc++) begin
      @(negedge clk);
      if (sb < 50) begin
        k = sb % 4;
        u3_a_v = 4'hF;
        u3_s_v = 1'b1;
        u3_s_d = 2'(k);
        u3_a_d = {4{8'hEE}};
        u3_a_d[k*8 +: 8] = 8'(sb);
      end else begin
        u3_a_v = 4'h0;
        u3_s_v = 1'b0;
      end
      u3_z_r = 1'($urandom_range(0, 1));
      #1;
      take = u3_s_v && u3_a_r[u3_s_d];
      pop  = u3_z_v && u3_z_r;
      if (pop) begin
        chk("t6_data", u3_z_d, 8'(rb));
        rb++;
      end
      if (take) sb++;
      if (sb - rb > occ_max) occ_max = sb - rb;
    end
    chk("t6_sent", sb, 50);
    chk("t6_received", rb, 50);
    chk("t6_occ_le_3", (occ_max <= 3), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
